adsr_envelope_engine: RTL

//  Time-multiplexed, parametrised ADSR envelope generator for NUM_VOICES voices.
//  Per-voice envelope and state live in an internal register array; one voice is processed per accepted beat.

---
 rtl/adsr_pkg.sv | 17 +
 rtl/adsr_step.sv | 104 ++++++++++
 rtl/adsr_envelope_engine.sv | 132 +++++++++++++
 3 files changed

// File: rtl/adsr_pkg.sv
// Shared definitions for the ADSR envelope engine: voice state encoding and envelope helpers.
package adsr_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ATTACK  = 3'd1,
        ST_DECAY   = 3'd2,
        ST_SUSTAIN = 3'd3,
        ST_RELEASE = 3'd4
    } adsr_state_t;

    // Full-scale envelope value for a given accumulator width.
    function automatic logic [63:0] env_max(input int unsigned width);
        return (64'd1 << width) - 64'd1;
    endfunction

endpackage

// File: rtl/adsr_step.sv
// Combinational next-state / next-envelope calculation for one voice.
// Release shape selected by ADSR_EXP_RELEASE_EN (exponential when defined, linear otherwise).
module adsr_step
    import adsr_pkg::*;
#(
    parameter int unsigned ENV_W     = 24,
    parameter int unsigned RATE_W    = 16,
    parameter int unsigned REL_SHIFT = 4
) (
    input  adsr_state_t       state,
    input  logic [ENV_W-1:0]  env,
    input  logic              gate,
    input  logic [RATE_W-1:0] attack_rate,
    input  logic [RATE_W-1:0] decay_rate,
    input  logic [RATE_W-1:0] sustain_level,
    input  logic [RATE_W-1:0] rel_rate,
    output adsr_state_t       state_new,
    output logic [ENV_W-1:0]  env_new
);

    localparam logic [ENV_W-1:0] ENV_MAX   = ENV_W'(env_max(ENV_W));
    localparam logic [ENV_W:0]   ENV_MAX_X = {1'b0, ENV_MAX};

    if (REL_SHIFT >= ENV_W) begin : g_bad_rel_shift
        $error("adsr_step: REL_SHIFT must be less than ENV_W");
    end

    logic [ENV_W:0] env_x;
    logic [ENV_W:0] rise;
    logic [ENV_W:0] decay_x;
    logic [ENV_W:0] target;
    logic [ENV_W:0] step;

    always_comb begin
        env_x   = {1'b0, env};
        rise    = env_x + (ENV_W+1)'(attack_rate);
        decay_x = (ENV_W+1)'(decay_rate);
        target  = (ENV_W+1)'(sustain_level) << (ENV_W - RATE_W);
        if (target > ENV_MAX_X) begin
            target = ENV_MAX_X;
        end
`ifdef ADSR_EXP_RELEASE_EN
        step = (env_x >> REL_SHIFT) + (ENV_W+1)'(1);
`else
        step = (ENV_W+1)'(rel_rate);
`endif

        state_new = state;
        env_new   = env;
        case (state)
            ST_IDLE: begin
                env_new = '0;
                if (gate) begin
                    state_new = ST_ATTACK;
                end
            end
            ST_ATTACK: begin
                if (!gate) begin
                    state_new = ST_RELEASE;
                end else if (attack_rate != '0) begin
                    if (rise >= ENV_MAX_X) begin
                        env_new   = ENV_MAX;
                        state_new = ST_DECAY;
                    end else begin
                        env_new = env + ENV_W'(attack_rate);
                    end
                end
            end
            ST_DECAY: begin
                // Floor test done on the widened sum so env - rate never underflows.
                if (!gate) begin
                    state_new = ST_RELEASE;
                end else if (decay_rate != '0) begin
                    if (env_x <= target + decay_x) begin
                        env_new   = ENV_W'(target);
                        state_new = ST_SUSTAIN;
                    end else begin
                        env_new = env - ENV_W'(decay_rate);
                    end
                end
            end
            ST_SUSTAIN: begin
                if (!gate) begin
                    state_new = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (gate) begin
                    state_new = ST_ATTACK;
                end else if (env_x <= step) begin
                    env_new   = '0;
                    state_new = ST_IDLE;
                end else begin
                    env_new = env - ENV_W'(step);
                end
            end
            default: begin
                state_new = ST_IDLE;
                env_new   = '0;
            end
        endcase
    end

endmodule

// File: rtl/adsr_envelope_engine.sv
// Time-multiplexed ADSR envelope engine: per-voice state array, 2-stage pipeline with forwarding.
// Optional exponential release via ADSR_EXP_RELEASE_EN.
module adsr_envelope_engine
    import adsr_pkg::*;
#(
    parameter int unsigned NUM_VOICES = 16,
    parameter int unsigned SAMPLE_W   = 16,
    parameter int unsigned ENV_W      = 24,
    parameter int unsigned RATE_W     = 16,
    parameter int unsigned REL_SHIFT  = 4,
    localparam int unsigned VOICE_W   = $clog2(NUM_VOICES)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    input  logic [VOICE_W-1:0]  in_voice,
    input  logic                in_gate,
    input  logic [SAMPLE_W-1:0] in_sample,
    input  logic [RATE_W-1:0]   attack_rate,
    input  logic [RATE_W-1:0]   decay_rate,
    input  logic [RATE_W-1:0]   sustain_level,
    input  logic [RATE_W-1:0]   rel_rate,
    output logic                out_valid,
    output logic [VOICE_W-1:0]  out_voice,
    output logic [SAMPLE_W-1:0] out_sample,
    output logic [NUM_VOICES-1:0] voice_active
);

    adsr_state_t        state_mem [NUM_VOICES];
    logic [ENV_W-1:0]   env_mem   [NUM_VOICES];

    logic                s1_valid;
    logic [VOICE_W-1:0]  s1_voice;
    logic                s1_gate;
    logic [SAMPLE_W-1:0] s1_sample;
    adsr_state_t         s1_state;
    logic [ENV_W-1:0]    s1_env;
    logic [RATE_W-1:0]   s1_attack;
    logic [RATE_W-1:0]   s1_decay;
    logic [RATE_W-1:0]   s1_sustain;
    logic [RATE_W-1:0]   s1_rel;

    adsr_state_t         step_state;
    logic [ENV_W-1:0]    step_env;
    logic                fwd;
    logic signed [2*SAMPLE_W:0] product;

    adsr_step #(
        .ENV_W     (ENV_W),
        .RATE_W    (RATE_W),
        .REL_SHIFT (REL_SHIFT)
    ) u_step (
        .state         (s1_state),
        .env           (s1_env),
        .gate          (s1_gate),
        .attack_rate   (s1_attack),
        .decay_rate    (s1_decay),
        .sustain_level (s1_sustain),
        .rel_rate      (s1_rel),
        .state_new     (step_state),
        .env_new       (step_env)
    );

    // The stored copy of a voice is stale while S2 is writing that same voice.
    assign fwd = s1_valid && (in_voice == s1_voice);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid   <= 1'b0;
            s1_voice   <= '0;
            s1_gate    <= 1'b0;
            s1_sample  <= '0;
            s1_state   <= ST_IDLE;
            s1_env     <= '0;
            s1_attack  <= '0;
            s1_decay   <= '0;
            s1_sustain <= '0;
            s1_rel     <= '0;
        end else begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_voice   <= in_voice;
                s1_gate    <= in_gate;
                s1_sample  <= in_sample;
                s1_state   <= fwd ? step_state : state_mem[in_voice];
                s1_env     <= fwd ? step_env   : env_mem[in_voice];
                s1_attack  <= attack_rate;
                s1_decay   <= decay_rate;
                s1_sustain <= sustain_level;
                s1_rel     <= rel_rate;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned v = 0; v < NUM_VOICES; v++) begin
                state_mem[v] <= ST_IDLE;
                env_mem[v]   <= '0;
            end
        end else if (s1_valid) begin
            state_mem[s1_voice] <= step_state;
            env_mem[s1_voice]   <= step_env;
        end
    end

    always_comb begin
        product = $signed(s1_sample) * $signed({1'b0, step_env[ENV_W-1 -: SAMPLE_W]});
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid  <= 1'b0;
            out_voice  <= '0;
            out_sample <= '0;
        end else begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_voice  <= s1_voice;
                out_sample <= SAMPLE_W'(product >>> SAMPLE_W);
            end
        end
    end

    always_comb begin
        voice_active = '0;
        for (int unsigned v = 0; v < NUM_VOICES; v++) begin
            voice_active[v] = (state_mem[v] != ST_IDLE);
        end
    end

endmodule
